// File: rtl/bl_zone_scheduler_pkg.sv
// rtl/bl_zone_scheduler_pkg.sv - shared constants, FSM encoding and gain helper for the zone scheduler
package bl_zone_scheduler_pkg;

    localparam int N_ZONES = 360;
    localparam int ZONES_X = 24;
    localparam int ZONES_Y = 15;
    localparam int ZONE_W  = 9;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_SEND
    } state_t;

    // d*(g+1)/256: full-scale gain is an exact identity, zero gain blanks the zone
    function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] d,
                                                     input logic [7:0] g);
        logic [16:0] p;
        p = 17'(d) * 17'(g) + 17'(d);
        return DATA_W'(p >> 8);
    endfunction

endpackage

// File: rtl/bl_zone_dpram.sv
// rtl/bl_zone_dpram.sv - ping-pong zone buffer, one write port and one synchronous read port
module bl_zone_dpram
    import bl_zone_scheduler_pkg::*;
#(
    parameter int ZONES = N_ZONES,
    parameter int ZW    = ZONE_W,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [ZW:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [ZW:0]   rd_addr,
    output logic [DW-1:0] rd_data
);

    // Address is {bank, idx}; the caller keeps idx below ZONES
    logic [DW-1:0] mem [2][ZONES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[ZW]][wr_addr[ZW-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[ZW]][rd_addr[ZW-1:0]];
    end

endmodule

// File: rtl/bl_zone_scheduler.sv
// rtl/bl_zone_scheduler.sv - captures zone values per frame and streams them gain-scaled to the LED driver
module bl_zone_scheduler
    import bl_zone_scheduler_pkg::*;
#(
    parameter int ZONES = N_ZONES,
    parameter int ZW    = ZONE_W,
    parameter int DW    = DATA_W
) (
    input  logic          i_pix_clk,
    input  logic          rst_n,
    input  logic          i_vsync,
    input  logic          i_zone_valid,
    input  logic [ZW-1:0] i_zone_idx,
    input  logic [DW-1:0] i_zone_data,
    input  logic [7:0]    i_gain,
    input  logic          i_tx_ready,
    output logic          o_tx_valid,
    output logic [ZW-1:0] o_tx_zone,
    output logic [DW-1:0] o_tx_data,
    output logic          o_tx_last,
    output logic          o_busy,
    output logic          o_bank,
    output logic          o_overrun
);

    state_t        state;
    state_t        state_nxt;
    logic          vsync_d;
    logic          vs_edge;
    logic          rd_bank;
    logic [7:0]    gain;
    logic [ZW-1:0] rd_ptr;
    logic [DW-1:0] ram_q;
    logic          wr_en;
    logic          is_last;
    logic          accept;

    assign vs_edge = i_vsync && !vsync_d;
    assign wr_en   = i_zone_valid && (i_zone_idx < ZW'(ZONES));
    assign is_last = (rd_ptr == ZW'(ZONES - 1));
    assign accept  = (state == ST_SEND) && i_tx_ready;

    // Write side uses the pre-swap bank, so a write coinciding with the edge joins this frame
    bl_zone_dpram #(.ZONES(ZONES), .ZW(ZW), .DW(DW)) u_dpram (
        .clk     (i_pix_clk),
        .wr_en   (wr_en),
        .wr_addr ({o_bank, i_zone_idx}),
        .wr_data (i_zone_data),
        .rd_addr ({rd_bank, rd_ptr}),
        .rd_data (ram_q)
    );

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (vs_edge) state_nxt = ST_RD;
            ST_RD:   state_nxt = ST_CALC;
            ST_CALC: state_nxt = ST_SEND;
            ST_SEND: if (i_tx_ready) state_nxt = is_last ? ST_IDLE : ST_RD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            o_bank    <= 1'b0;
            rd_bank   <= 1'b0;
            gain      <= 8'hFF;
            rd_ptr    <= '0;
            o_tx_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            vsync_d <= i_vsync;
            if (vs_edge) begin
                if (state == ST_IDLE) begin
                    o_bank  <= ~o_bank;
                    rd_bank <= o_bank;
                    gain    <= i_gain;
                    rd_ptr  <= '0;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
            if (state == ST_CALC) begin
                o_tx_data <= apply_gain(ram_q, gain);
            end
            if (accept && !is_last) begin
                rd_ptr <= rd_ptr + ZW'(1);
            end
        end
    end

    assign o_tx_valid = (state == ST_SEND);
    assign o_tx_zone  = rd_ptr;
    assign o_tx_last  = o_tx_valid && is_last;
    assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_bl_zone_scheduler.sv
// tb/tb_bl_zone_scheduler.sv - randomized self-checking bench for bl_zone_scheduler
module tb_bl_zone_scheduler;

    localparam int ZN = 360;

    logic       clk;
    logic       rst_n;
    logic       i_vsync;
    logic       i_zone_valid;
    logic [8:0] i_zone_idx;
    logic [7:0] i_zone_data;
    logic [7:0] i_gain;
    logic       i_tx_ready;
    logic       o_tx_valid;
    logic [8:0] o_tx_zone;
    logic [7:0] o_tx_data;
    logic       o_tx_last;
    logic       o_busy;
    logic       o_bank;
    logic       o_overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [2][ZN];
    logic [7:0] rx_data [ZN];
    int wbank;
    int rbank;
    int gain_m;
    bit overrun_m;

    bl_zone_scheduler dut (
        .i_pix_clk    (clk),
        .rst_n        (rst_n),
        .i_vsync      (i_vsync),
        .i_zone_valid (i_zone_valid),
        .i_zone_idx   (i_zone_idx),
        .i_zone_data  (i_zone_data),
        .i_gain       (i_gain),
        .i_tx_ready   (i_tx_ready),
        .o_tx_valid   (o_tx_valid),
        .o_tx_zone    (o_tx_zone),
        .o_tx_data    (o_tx_data),
        .o_tx_last    (o_tx_last),
        .o_busy       (o_busy),
        .o_bank       (o_bank),
        .o_overrun    (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int scaled(input int d, input int g);
        return (d * (g + 1)) / 256;
    endfunction

    task automatic write_zone(input int idx, input int data);
        i_zone_valid = 1'b1;
        i_zone_idx   = 9'(idx);
        i_zone_data  = 8'(data);
        if (idx < ZN) model[wbank][idx] = 8'(data);
        @(posedge clk); #1;
        i_zone_valid = 1'b0;
    endtask

    task automatic fill(input bit rnd);
        for (int k = 0; k < ZN; k++) begin
            i_zone_valid = 1'b1;
            i_zone_idx   = 9'(k);
            i_zone_data  = rnd ? 8'($urandom) : 8'(k);
            model[wbank][k] = i_zone_data;
            @(posedge clk); #1;
        end
        i_zone_valid = 1'b0;
    endtask

    task automatic vsync_swap(input int g, input int wr_idx, input int wr_data);
        @(posedge clk); #1;
        i_gain  = 8'(g);
        i_vsync = 1'b1;
        if (wr_idx >= 0) begin
            i_zone_valid = 1'b1;
            i_zone_idx   = 9'(wr_idx);
            i_zone_data  = 8'(wr_data);
            if (wr_idx < ZN) model[wbank][wr_idx] = 8'(wr_data);
        end
        @(posedge clk); #1;
        i_vsync      = 1'b0;
        i_zone_valid = 1'b0;
        rbank  = wbank;
        wbank  = wbank ^ 1;
        gain_m = g;
        checks++;
        if (o_bank !== wbank[0] || o_busy !== 1'b1) begin
            $display("FAIL swap bank=%b busy=%b required bank=%b busy=1", o_bank, o_busy, wbank[0]);
            failures++;
        end
    endtask

    task automatic recv_frame(input int stall_beat, input bit rnd, input int ovr_beat, input int rst_beat);
        int wait_c;
        int n;
        logic [7:0] exp_d;
        logic [8:0] z0;
        logic [7:0] d0;
        i_tx_ready = 1'b1;
        for (int beat = 0; beat < ZN; beat++) begin
            wait_c = 0;
            while (o_tx_valid !== 1'b1 && wait_c < 20) begin
                @(posedge clk); #1;
                wait_c++;
            end
            checks++;
            if (o_tx_valid !== 1'b1) begin
                $display("FAIL beat_timeout beat=%0d valid=%b required=1", beat, o_tx_valid);
                failures++;
                return;
            end
            if (beat > 0) begin
                checks++;
                if (wait_c != 2) begin
                    $display("FAIL beat_gap beat=%0d gap=%0d required=2", beat, wait_c);
                    failures++;
                end
            end
            exp_d = 8'(scaled(int'(model[rbank][beat]), gain_m));
            checks++;
            if (o_tx_zone !== 9'(beat) || o_tx_data !== exp_d || o_tx_last !== (beat == ZN - 1)) begin
                $display("FAIL beat zone=%0d data=%0d last=%b required zone=%0d data=%0d last=%b",
                         o_tx_zone, o_tx_data, o_tx_last, beat, exp_d, beat == ZN - 1);
                failures++;
            end
            rx_data[beat] = o_tx_data;
            if (beat == rst_beat) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({o_tx_valid, o_tx_zone, o_tx_data, o_tx_last, o_busy, o_bank, o_overrun} !== 22'd0) begin
                    $display("FAIL reset_abort valid=%b zone=%0d data=%0d last=%b busy=%b bank=%b ovr=%b required all 0",
                             o_tx_valid, o_tx_zone, o_tx_data, o_tx_last, o_busy, o_bank, o_overrun);
                    failures++;
                end
                wbank = 0;
                overrun_m = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            n  = (beat == stall_beat) ? 10 : (rnd ? int'($urandom_range(0, 2)) : 0);
            z0 = o_tx_zone;
            d0 = o_tx_data;
            for (int s = 0; s < n; s++) begin
                i_tx_ready = 1'b0;
                @(posedge clk); #1;
                checks++;
                if (o_tx_valid !== 1'b1 || o_tx_zone !== z0 || o_tx_data !== d0) begin
                    $display("FAIL stall_hold valid=%b zone=%0d data=%0d required valid=1 zone=%0d data=%0d",
                             o_tx_valid, o_tx_zone, o_tx_data, z0, d0);
                    failures++;
                end
            end
            i_tx_ready = 1'b1;
            if (beat == ovr_beat) begin
                i_vsync   = 1'b1;
                overrun_m = 1'b1;
            end
            @(posedge clk); #1;
            i_vsync = 1'b0;
            if (beat == ovr_beat) begin
                checks++;
                if (o_overrun !== 1'b1 || o_bank !== wbank[0]) begin
                    $display("FAIL overrun_edge ovr=%b bank=%b required ovr=1 bank=%b", o_overrun, o_bank, wbank[0]);
                    failures++;
                end
            end
        end
        checks++;
        if (o_busy !== 1'b0) begin
            $display("FAIL busy_after_last busy=%b required=0", o_busy);
            failures++;
        end
        checks++;
        if (o_overrun !== overrun_m) begin
            $display("FAIL overrun_flag ovr=%b required=%b", o_overrun, overrun_m);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_tx_valid, o_tx_zone, o_tx_data, o_tx_last, o_busy, o_bank, o_overrun} !== 22'd0) begin
            $display("FAIL reset_state valid=%b zone=%0d data=%0d last=%b busy=%b bank=%b ovr=%b required all 0",
                     o_tx_valid, o_tx_zone, o_tx_data, o_tx_last, o_busy, o_bank, o_overrun);
            failures++;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wbank = 0;
        overrun_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame();
        fill(1'b0);
        vsync_swap(255, -1, 0);
        recv_frame(-1, 1'b0, -1, -1);
    endtask

    task automatic test_gain();
        fill(1'b1);
        write_zone(5, 17);
        write_zone(5, 200);
        vsync_swap(128, -1, 0);
        recv_frame(-1, 1'b1, -1, -1);
        checks++;
        if (rx_data[5] !== 8'd100) begin
            $display("FAIL gain_128 data=%0d required=100", rx_data[5]);
            failures++;
        end
        fill(1'b1);
        write_zone(5, 200);
        vsync_swap(0, -1, 0);
        recv_frame(-1, 1'b1, -1, -1);
        checks++;
        if (rx_data[5] !== 8'd0) begin
            $display("FAIL gain_0 data=%0d required=0", rx_data[5]);
            failures++;
        end
        fill(1'b1);
        write_zone(6, 255);
        vsync_swap(255, -1, 0);
        recv_frame(-1, 1'b1, -1, -1);
        checks++;
        if (rx_data[6] !== 8'd255) begin
            $display("FAIL gain_255 data=%0d required=255", rx_data[6]);
            failures++;
        end
    endtask

    task automatic test_backpressure();
        fill(1'b1);
        vsync_swap(int'($urandom_range(0, 255)), -1, 0);
        recv_frame(3, 1'b0, -1, -1);
    endtask

    task automatic test_overrun();
        fill(1'b1);
        vsync_swap(200, -1, 0);
        recv_frame(-1, 1'b0, 100, -1);
        fill(1'b1);
        vsync_swap(90, -1, 0);
        recv_frame(-1, 1'b1, -1, -1);
    endtask

    task automatic test_range_and_coincident();
        fill(1'b1);
        write_zone(360, 8'h5A);
        write_zone(511, 8'hC3);
        vsync_swap(255, 7, 8'hAA);
        recv_frame(-1, 1'b1, -1, -1);
        checks++;
        if (rx_data[7] !== 8'hAA) begin
            $display("FAIL coincident_write data=%0h required=aa", rx_data[7]);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        fill(1'b1);
        vsync_swap(255, -1, 0);
        recv_frame(-1, 1'b0, -1, 50);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_tx_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL quiet_after_reset beats=%0d required=0", seen);
            failures++;
        end
        fill(1'b1);
        vsync_swap(int'($urandom_range(0, 255)), -1, 0);
        recv_frame(-1, 1'b1, -1, -1);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_vsync      = 1'b0;
        i_zone_valid = 1'b0;
        i_zone_idx   = '0;
        i_zone_data  = '0;
        i_gain       = '0;
        i_tx_ready   = 1'b0;
        test_reset();
        test_full_frame();
        test_gain();
        test_backpressure();
        test_overrun();
        test_range_and_coincident();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bl_zone_scheduler.md
Name: bl_zone_scheduler

Overview:
- Frame-level controller between the 360-zone backlight computation (24x15 zones) and the LED driver interface.
- Captures per-zone backlight values into a ping-pong zone buffer as they are produced during a frame.
- Swaps banks at the frame boundary, then sequences all 360 zones out over a valid/ready stream with a global brightness gain applied.
- Flags frames whose transmission overran the next frame boundary.

Parameters:
- ZONES, 360, number of backlight zones per frame
- ZW, 9, zone index width
- DW, 8, zone value width

Ports:
- i_pix_clk  in  1  pixel clock
- rst_n  in  1  reset
- i_vsync  in  1  frame sync level; rising edge marks the frame boundary
- i_zone_valid  in  1  zone value present this cycle (may stay high several cycles for the same zone)
- i_zone_idx  in  ZW  zone index of i_zone_data
- i_zone_data  in  DW  zone backlight value
- i_gain  in  8  global gain, sampled at bank swap
- i_tx_ready  in  1  LED driver accepts the beat
- o_tx_valid  out  1  output beat valid
- o_tx_zone  out  ZW  zone index of the beat
- o_tx_data  out  DW  scaled zone value
- o_tx_last  out  1  high on the beat for zone ZONES-1
- o_busy  out  1  transmission in progress (state not IDLE)
- o_bank  out  1  current write bank
- o_overrun  out  1  sticky; cleared only by reset

Behaviour:
- Reset, clocking and reset values:
  - Reset rst_n, asynchronous, active-low; clock i_pix_clk.
  - On reset all outputs are 0: o_tx_valid, o_tx_zone, o_tx_data, o_tx_last, o_busy, o_bank, o_overrun.
  - FSM goes to IDLE, read pointer = 0, latched gain = 0xFF. RAM contents are undefined after reset.
- Zone buffer: 2 banks x ZONES x DW.
  - Write: when i_zone_valid && i_zone_idx < ZONES, write mem[o_bank][i_zone_idx] = i_zone_data in the same cycle.
  - i_zone_idx >= ZONES is ignored.
  - Repeated writes to the same index: the last value wins.
  - Zones not written in a frame keep their stale content.
- Frame edge: vs_edge = i_vsync && !vsync_d, where vsync_d is registered. Detection latency is 1 cycle.
- Swap, taken on vs_edge when the FSM is in IDLE:
  - o_bank toggles.
  - The read bank becomes the old write bank.
  - i_gain is latched.
  - Read pointer is cleared.
  - FSM goes IDLE->RD in the next cycle.
- Overrun, on vs_edge when the FSM is not IDLE:
  - No swap; the current transmission continues unaffected.
  - The write bank is overwritten next frame.
  - o_overrun is set to 1.
- A write and a swap in the same cycle: the write goes to the pre-swap bank.
- FSM:
  - IDLE: o_busy = 0.
  - RD: issue RAM read at rd_ptr; go to CALC.
  - CALC: register the RAM output into o_tx_data; go to SEND.
    - Scaling: o_tx_data = (d*g + d) >> 8, using a 17-bit product; the result always fits in 8 bits.
    - g = 0xFF gives identity; g = 0 gives 0.
  - SEND: o_tx_valid = 1, with o_tx_zone = rd_ptr and o_tx_last = (rd_ptr == ZONES-1).
    - The beat is held stable while !i_tx_ready.
    - On i_tx_ready: o_tx_valid drops next cycle.
    - If last, go to IDLE; else rd_ptr++ and go to RD.
  - Throughput: one zone per 3 cycles minimum. A full frame takes 1080 cycles, plus ready stalls.
- i_tx_ready is ignored when o_tx_valid = 0.
- Reset asserted mid-transmission aborts immediately. After release, nothing is sent until the next vs_edge.

Decomposition:
- Shared package holds:
  - ZONES = 360, zones per row = 24, zone rows = 15.
  - Zone index/value widths.
  - FSM state encoding: IDLE, RD, CALC, SEND.
- Natural sub-module: bl_zone_dpram, a simple dual-port RAM of 2*ZONES x DW.
  - Address = {bank, idx}.
  - Synchronous read, 1-cycle latency, write-first not required.

Test Plan:
1. Write zone k = k[7:0] for all 360, pulse vsync, i_gain = 0xFF, tx_ready held 1:
   - 360 beats, zone 0..359, data = k & 0xFF, o_tx_last only on zone 359.
   - o_bank 0->1; o_busy falls 1 cycle after the last accept.
2. Gain scaling: zone 5 = 200, gain = 128:
   - o_tx_data = 100.
   - With gain 0, data = 0; with zone = 255 and gain 255, data = 255.
3. Backpressure: tx_ready low for 10 cycles on beat 3:
   - valid, zone 3 and data held constant for 10 cycles.
   - Zone 4 is presented 3 cycles after the accept.
4. Overrun: second vsync edge while on beat 100:
   - o_overrun = 1, o_bank unchanged, beats 101..359 still sent from the same bank.
   - Next vsync in IDLE swaps normally.
5. Out-of-range and same-cycle swap:
   - Write with idx = 360 leaves the RAM unchanged.
   - Write of zone 7 = 0xAA coincident with vs_edge lands in the pre-swap bank and is transmitted this frame.
6. Reset asserted at beat 50:
   - All outputs 0 immediately.
   - After release, no beats until the next vsync edge; the first beat is zone 0.
